ram_bist_ctrl: RTL and testbench

- Memory built-in self-test initiator that drives the RAM's native interface: wr, wr_addr, d_in, rd_addr_a and rd_addr_b out; d_out_a and d_out_b in.
- Runs a March C- sequence over the full address space and checks both read ports on every read.
- Reports pass/fail plus the first failing address, data and port.
- Sits beside the RAM and is muxed onto its ports during test. The RAM read path is combinational and the write commits on the clk rising edge.

---
 rtl/ram_bist_pkg.sv | 45 ++++
 rtl/bist_addr_gen.sv | 28 ++
 rtl/ram_bist_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types and March C- element table for the RAM BIST controller.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int NUM_ELEM = 6;

    localparam logic [2:0] ELEM_W0_UP   = 3'd0;
    localparam logic [2:0] ELEM_R0W1_UP = 3'd1;
    localparam logic [2:0] ELEM_R1W0_UP = 3'd2;
    localparam logic [2:0] ELEM_R0W1_DN = 3'd3;
    localparam logic [2:0] ELEM_R1W0_DN = 3'd4;
    localparam logic [2:0] ELEM_R0_DN   = 3'd5;

    typedef struct packed {
        logic has_rd;
        logic has_wr;
        logic rd_val;
        logic wr_val;
        logic dir_down;
    } elem_attr_t;

    // Value bits select background (0) or inverted background (1).
    function automatic elem_attr_t elem_attr(input logic [2:0] elem);
        elem_attr_t a;
        a = '0;
        case (elem)
            ELEM_W0_UP:   a = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            ELEM_R0W1_UP: a = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            ELEM_R1W0_UP: a = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            ELEM_R0W1_DN: a = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            ELEM_R1W0_DN: a = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
            ELEM_R0_DN:   a = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            default:      a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down address counter for the BIST; load picks 0 or N-1 from the direction.
module bist_addr_gen #(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic          dir_down,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
        end else if (load) begin
            addr <= dir_down ? '1 : '0;
        end else if (step) begin
            addr <= dir_down ? addr - ONE : addr + ONE;
        end
    end

    assign last = dir_down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST initiator for a dual-read-port RAM.
// Define BIST_ERR_CNT_EN to count failing reads and run to completion instead of aborting.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int              AW      = 18,
    parameter int              DW      = 16,
    parameter logic [DW-1:0]   PATTERN = 16'hA5A5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output logic          fail_port,
`ifdef BIST_ERR_CNT_EN
    output logic [15:0]   err_count,
`endif
    output logic          wr,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] d_in,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    input  logic [DW-1:0] d_out_a,
    input  logic [DW-1:0] d_out_b
);

`ifdef BIST_ERR_CNT_EN
    localparam logic ABORT_ON_FAIL = 1'b0;
`else
    localparam logic ABORT_ON_FAIL = 1'b1;
`endif

    state_t        state, state_next;
    logic [2:0]    elem, elem_next, attr_sel;
    elem_attr_t    attr;
    logic [AW-1:0] addr;
    logic          addr_last, ag_load, ag_step;
    logic [DW-1:0] exp_val, wr_val;
    logic          a_bad, b_bad, mismatch, fail_found;

    // In S_NEXT the attributes already describe the upcoming element so the
    // address counter reloads in the right direction.
    assign attr_sel = (state == S_IDLE) ? ELEM_W0_UP :
                      (state == S_NEXT) ? elem + 3'd1 : elem;
    assign attr     = elem_attr(attr_sel);
    assign exp_val  = attr.rd_val ? ~PATTERN : PATTERN;
    assign wr_val   = attr.wr_val ? ~PATTERN : PATTERN;
    assign a_bad    = (d_out_a != exp_val);
    assign b_bad    = (d_out_b != exp_val);
    assign mismatch = (state == S_RD) && (a_bad || b_bad);

    bist_addr_gen #(.AW(AW)) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (ag_load),
        .step     (ag_step),
        .dir_down (attr.dir_down),
        .addr     (addr),
        .last     (addr_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            elem  <= '0;
        end else begin
            state <= state_next;
            elem  <= elem_next;
        end
    end

    always_comb begin
        state_next = state;
        elem_next  = elem;
        ag_load    = 1'b0;
        ag_step    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    elem_next  = ELEM_W0_UP;
                    ag_load    = 1'b1;
                    state_next = attr.has_rd ? S_RD : S_WR;
                end
            end
            S_RD: begin
                if (mismatch && ABORT_ON_FAIL) begin
                    state_next = S_DONE;
                end else if (attr.has_wr) begin
                    state_next = S_WR;
                end else if (addr_last) begin
                    state_next = S_NEXT;
                end else begin
                    ag_step = 1'b1;
                end
            end
            S_WR: begin
                if (addr_last) begin
                    state_next = S_NEXT;
                end else begin
                    ag_step    = 1'b1;
                    state_next = attr.has_rd ? S_RD : S_WR;
                end
            end
            S_NEXT: begin
                if (elem == ELEM_R0_DN) begin
                    state_next = S_DONE;
                end else begin
                    elem_next  = elem + 3'd1;
                    ag_load    = 1'b1;
                    state_next = attr.has_rd ? S_RD : S_WR;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Port a takes priority when both ports disagree on the first failing read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
            fail_port  <= 1'b0;
            fail_found <= 1'b0;
        end else if (state == S_IDLE && start) begin
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
            fail_port  <= 1'b0;
            fail_found <= 1'b0;
        end else begin
            if (mismatch && !fail_found) begin
                fail_addr  <= addr;
                fail_data  <= a_bad ? d_out_a : d_out_b;
                fail_port  <= !a_bad;
                fail_found <= 1'b1;
            end
            if (state_next == S_DONE) begin
                pass <= !(fail_found || mismatch);
            end
        end
    end

`ifdef BIST_ERR_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (state == S_IDLE && start) begin
            err_count <= '0;
        end else if (mismatch && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

    assign busy      = (state == S_RD) || (state == S_WR) || (state == S_NEXT);
    assign done      = (state == S_DONE);
    assign wr        = (state == S_WR);
    assign wr_addr   = busy ? addr : '0;
    assign rd_addr_a = busy ? addr : '0;
    assign rd_addr_b = busy ? addr : '0;
    assign d_in      = busy ? wr_val : '0;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl (AW=4) with a behavioural dual-read RAM and fault injection.
`timescale 1ns/1ps
module tb_ram_bist_ctrl;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, pass, fail_port, wr;
    logic [AW-1:0] fail_addr, wr_addr, rd_addr_a, rd_addr_b;
    logic [DW-1:0] fail_data, d_in, d_out_a, d_out_b;
`ifdef BIST_ERR_CNT_EN
    logic [15:0]   err_count;
`endif

    logic [DW-1:0] mem [N];
    logic          stuck_en = 1'b0;
    logic          portb_en = 1'b0;

    int checks = 0;
    int failures = 0;
    int busy_cnt, wr_cnt;
    logic done_seen;
    logic [AW-1:0] wr_addr_log [200];
    logic [DW-1:0] d_in_log [200];

    ram_bist_ctrl #(.AW(AW), .DW(DW), .PATTERN(16'hA5A5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .fail_port (fail_port),
`ifdef BIST_ERR_CNT_EN
        .err_count (err_count),
`endif
        .wr        (wr),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b)
    );

    always #5 clk = ~clk;

    // Word 5 bit 0 stuck at 0 when enabled; port b of word 3 reads zero when enabled.
    always @(posedge clk) begin
        if (wr) mem[wr_addr] <= (stuck_en && wr_addr == 4'd5) ? (d_in & 16'hFFFE) : d_in;
    end
    assign d_out_a = mem[rd_addr_a];
    assign d_out_b = (portb_en && rd_addr_b == 4'd3) ? 16'h0000 : mem[rd_addr_b];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Start one run and follow it cycle by cycle until done, or pull reset at cycle reset_at.
    task automatic applyStimulus(input int pulse_at, input int reset_at);
        busy_cnt  = 0;
        wr_cnt    = 0;
        done_seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            start = (cyc == pulse_at);
            if (busy) busy_cnt++;
            if (wr && wr_cnt < 200) begin
                wr_addr_log[wr_cnt] = wr_addr;
                d_in_log[wr_cnt]    = d_in;
                wr_cnt++;
            end
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            if (cyc == reset_at) begin
                checkOutput("pre_reset_wr", wr, 1);
                reset = 1'b0;
                #1;
                checkOutput("async_wr", wr, 0);
                checkOutput("async_busy", busy, 0);
                checkOutput("async_done", done, 0);
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        $display("[TB] ram_bist_ctrl directed test start");
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_wr", wr, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_fail_addr", fail_addr, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_d_in", d_in, 0);
        reset = 1'b1;
        @(negedge clk);

        // Fault-free run
        applyStimulus(-1, -1);
        checkOutput("t1_done", done_seen, 1);
        checkOutput("t1_busy_cycles", busy_cnt, 166);
        checkOutput("t1_wr_cycles", wr_cnt, 80);
        checkOutput("t1_pass", pass, 1);
        for (int i = 0; i < N; i++) checkOutput($sformatf("t1_mem%0d", i), mem[i], 16'hA5A5);
        @(negedge clk);
        checkOutput("t1_done_one_cycle", done, 0);
        checkOutput("t1_pass_hold", pass, 1);

        // Stuck-at-0 bit 0 of word 5
        stuck_en = 1'b1;
        applyStimulus(-1, -1);
        checkOutput("t2_done", done_seen, 1);
        checkOutput("t2_pass", pass, 0);
        checkOutput("t2_fail_addr", fail_addr, 5);
        checkOutput("t2_fail_data", fail_data, 16'hA5A4);
        checkOutput("t2_fail_port", fail_port, 0);
`ifdef BIST_ERR_CNT_EN
        checkOutput("t2_busy_cycles", busy_cnt, 166);
        checkOutput("t2_wr_cycles", wr_cnt, 80);
        checkOutput("t2_err_count", err_count, 3);
`else
        checkOutput("t2_busy_cycles", busy_cnt, 28);
        checkOutput("t2_wr_cycles", wr_cnt, 21);
`endif
        stuck_en = 1'b0;

        // Port b reads zero at word 3
        portb_en = 1'b1;
        applyStimulus(-1, -1);
        checkOutput("t3_done", done_seen, 1);
        checkOutput("t3_pass", pass, 0);
        checkOutput("t3_fail_addr", fail_addr, 3);
        checkOutput("t3_fail_data", fail_data, 16'h0000);
        checkOutput("t3_fail_port", fail_port, 1);
`ifdef BIST_ERR_CNT_EN
        checkOutput("t3_busy_cycles", busy_cnt, 166);
        checkOutput("t3_err_count", err_count, 5);
`else
        checkOutput("t3_busy_cycles", busy_cnt, 24);
        checkOutput("t3_wr_cycles", wr_cnt, 19);
`endif
        @(negedge clk);
        checkOutput("t3_fail_addr_hold", fail_addr, 3);
        portb_en = 1'b0;

        // Clean run with a stray start pulse; element 3 writes walk down with 5A5A
        applyStimulus(100, -1);
        checkOutput("t4_done", done_seen, 1);
        checkOutput("t4_busy_cycles", busy_cnt, 166);
        checkOutput("t4_pass", pass, 1);
        checkOutput("t4_fail_addr_clr", fail_addr, 0);
        checkOutput("t4_fail_data_clr", fail_data, 0);
        checkOutput("t4_fail_port_clr", fail_port, 0);
`ifdef BIST_ERR_CNT_EN
        checkOutput("t4_err_count", err_count, 0);
`endif
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("t4_e3_addr%0d", k), wr_addr_log[48 + k], 15 - k);
            checkOutput($sformatf("t4_e3_data%0d", k), d_in_log[48 + k], 16'h5A5A);
        end

        // Reset during element 2, then a full clean run
        applyStimulus(-1, 61);
        @(negedge clk);
        reset = 1'b1;
        checkOutput("t5_idle_busy", busy, 0);
        checkOutput("t5_idle_pass", pass, 0);
        applyStimulus(-1, -1);
        checkOutput("t5_done", done_seen, 1);
        checkOutput("t5_busy_cycles", busy_cnt, 166);
        checkOutput("t5_pass", pass, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
